tt_um_kavinmalar_serial_adder: RTL and testbench

Bit-serial 8-bit adder tile that sits directly downstream of the half-adder cell. It chains two half-adder stages and a carry flip-flop into a full adder, then applies it one bit per clock to two loaded operands. It produces an 8-bit sum plus carry-out with busy/done status. The block is a standalone Tiny Tapeout user tile with the standard tile pinout.

---
 rtl/tt_um_kavinmalar_serial_adder.sv | 115 +++++++++++
 tb/tb_tt_um_kavinmalar_serial_adder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tt_um_kavinmalar_serial_adder.sv
// Bit-serial 8-bit adder tile: two half adders plus a carry flop,
// applied LSB-first to the loaded operands, one bit per enabled clock.
module tt_um_kavinmalar_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       cnt;
  logic             c_q, cout_q, start_q;

  logic load_a, load_b, start, start_ev, last;
  logic h1, g1, s, g2, c_next;
  logic busy, done;

  assign load_a   = uio_in[0];
  assign load_b   = uio_in[1];
  assign start    = uio_in[2];
  assign start_ev = start & ~start_q;
  assign last     = (cnt == 3'(WIDTH - 1));

  logic unused_in;
  assign unused_in = &{1'b0, uio_in[7:3]};

  // Full adder built from two half-adder stages
  assign h1     = a_sh[0] ^ b_sh[0];
  assign g1     = a_sh[0] & b_sh[0];
  assign s      = h1 ^ c_q;
  assign g2     = h1 & c_q;
  assign c_next = g1 | g2;

  always_ff @(posedge clk) begin
    if (!rst_n)   state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_ev) state_d = RUN;
      RUN:        if (last)     state_d = DONE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      result_q <= '0;
      cnt      <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      start_q  <= 1'b0;
    end else if (ena) begin
      start_q <= start;
      unique case (state_q)
        IDLE, DONE: begin
          if (load_a) a_reg <= ui_in;
          if (load_b) b_reg <= ui_in;
          // Start sees the pre-load operands
          if (start_ev) begin
            a_sh <= a_reg;
            b_sh <= b_reg;
            s_sh <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          s_sh <= {s, s_sh[WIDTH-1:1]};
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          c_q  <= c_next;
          cnt  <= cnt + 3'd1;
          if (last) begin
            result_q <= {s, s_sh[WIDTH-1:1]};
            cout_q   <= c_next;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    uo_out  = result_q;
    uio_out = {1'b0, cout_q, done, busy, 4'b0000};
    uio_oe  = 8'b0111_0000;
  end

endmodule

// File: tb/tb_tt_um_kavinmalar_serial_adder.sv
// Bench for the serial adder tile: vector table, random sums,
// and hand sequences for ignore/re-run, mid-run reset and stall.
module tb_tt_um_kavinmalar_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  tt_um_kavinmalar_serial_adder dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] last_res = 8'h00;

  task automatic check(input string name, input logic [8:0] act,
                       input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk); ui_in = a; uio_in = 8'h01;
    @(negedge clk); ui_in = b; uio_in = 8'h02;
    @(negedge clk); uio_in = 8'h00;
  endtask

  task automatic start_op(input logic [7:0] sum, input logic cout,
                          input bit hold);
    exp_t e;
    e.sum = sum;
    e.cout = cout;
    sb.push_back(e);
    uio_in[2] = 1'b1;
    @(negedge clk);
    if (!hold) uio_in[2] = 1'b0;
  endtask

  task automatic wait_done(input int exp_busy, input string tag);
    int n = 0;
    int g = 0;
    exp_t e;
    check({tag, " hold"}, {1'b0, uo_out}, {1'b0, last_res});
    while (uio_out[4] && g < 40) begin
      n++;
      @(negedge clk);
      g++;
    end
    check({tag, " busy_cycles"}, 9'(n), 9'(exp_busy));
    check({tag, " done"}, {8'h00, uio_out[5]}, 9'd1);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %0h", tag, uo_out);
    end else begin
      e = sb.pop_front();
      check({tag, " result"}, {uio_out[6], uo_out}, {e.cout, e.sum});
      last_res = e.sum;
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] rs;

    vecs[0] = '{a: 8'h2D, b: 8'h5A, sum: 8'h87, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, cout: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, sum: 8'h00, cout: 1'b0};

    // Reset with random inputs
    repeat (2) begin
      ui_in = 8'($urandom);
      uio_in = 8'($urandom);
      @(negedge clk);
    end
    check("rst uo_out", {1'b0, uo_out}, 9'h000);
    check("rst uio_out", {1'b0, uio_out}, 9'h000);
    check("rst uio_oe", {1'b0, uio_oe}, 9'h070);
    uio_in = 8'h00;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      load_ops(vecs[i].a, vecs[i].b);
      start_op(vecs[i].sum, vecs[i].cout, 1'b0);
      wait_done(8, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = {1'b0, ra} + {1'b0, rb};
      load_ops(ra, rb);
      start_op(rs[7:0], rs[8], 1'b0);
      wait_done(8, $sformatf("rnd%0d", i));
    end

    // Loads and held start ignored during RUN, then re-run
    load_ops(8'h2D, 8'h5A);
    start_op(8'h87, 1'b0, 1'b1);
    ui_in = 8'h11;
    uio_in = 8'h05;
    wait_done(8, "ignore");
    uio_in = 8'h04;
    repeat (3) @(negedge clk);
    check("held start busy", {8'h00, uio_out[4]}, 9'd0);
    check("held start done", {8'h00, uio_out[5]}, 9'd1);
    uio_in = 8'h00;
    @(negedge clk);
    start_op(8'h87, 1'b0, 1'b0);
    wait_done(8, "rerun");

    // Reset in the middle of a run
    uio_in[2] = 1'b1;
    @(negedge clk);
    uio_in[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun busy", {8'h00, uio_out[4]}, 9'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst uio_out", {1'b0, uio_out}, 9'h000);
    check("midrst uo_out", {1'b0, uo_out}, 9'h000);
    rst_n = 1'b1;
    last_res = 8'h00;
    load_ops(8'h03, 8'h05);
    start_op(8'h08, 1'b0, 1'b0);
    wait_done(8, "after_rst");

    // Stall for 5 cycles mid-run
    load_ops(8'h80, 8'h80);
    start_op(8'h00, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d busy", i), {8'h00, uio_out[4]}, 9'd1);
    end
    check("stall uo_out", {1'b0, uo_out}, {1'b0, last_res});
    ena = 1'b1;
    @(negedge clk);
    wait_done(5, "stall");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
